// File: rtl/axil_reg_master.sv
// AXI4-Lite master that runs one register access per command and returns data, response and a
// timeout flag on a valid/ready response port. All AXI and response outputs are registered.
module axil_reg_master #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    M_AXI_ACLK,
   input  logic                    M_AXI_ARESET,
   // command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_wr,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // response port
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   // AXI4-Lite master
   output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]              M_AXI_AWPROT,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]              M_AXI_ARPROT,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StWr, StWrResp, StRdAddr, StRdData, StRsp
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic            wr_done, active, expired, tmo_fire;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
   assign b_hs  = M_AXI_BVALID & M_AXI_BREADY;
   assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
   assign r_hs  = M_AXI_RVALID & M_AXI_RREADY;

   // A valid that is already low in StWr means that channel has completed its handshake.
   assign wr_done = (~M_AXI_AWVALID | M_AXI_AWREADY) & (~M_AXI_WVALID | M_AXI_WREADY);

   assign active  = (state_q == StWr) | (state_q == StWrResp) |
                    (state_q == StRdAddr) | (state_q == StRdData);
   assign expired = (cnt_q == CntLast);

   // A handshake completing on the expiry edge takes priority over the abort.
   assign tmo_fire = expired & (((state_q == StWr) & ~wr_done) |
                                ((state_q == StWrResp) & ~b_hs) |
                                ((state_q == StRdAddr) & ~ar_hs) |
                                ((state_q == StRdData) & ~r_hs));

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_timeout   <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         if (active) begin
            cnt_q <= cnt_q + 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  cnt_q     <= '0;
                  if (cmd_wr) begin
                     M_AXI_AWADDR  <= cmd_addr;
                     M_AXI_WDATA   <= cmd_wdata;
                     M_AXI_WSTRB   <= cmd_wstrb;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     state_q       <= StWr;
                  end else begin
                     M_AXI_ARADDR  <= cmd_addr;
                     M_AXI_ARVALID <= 1'b1;
                     state_q       <= StRdAddr;
                  end
               end
            end
            StWr: begin
               if (aw_hs) begin
                  M_AXI_AWVALID <= 1'b0;
               end
               if (w_hs) begin
                  M_AXI_WVALID <= 1'b0;
               end
               if (wr_done) begin
                  M_AXI_BREADY <= 1'b1;
                  state_q      <= StWrResp;
               end
            end
            StWrResp: begin
               if (b_hs) begin
                  M_AXI_BREADY <= 1'b0;
                  rsp_rdata    <= '0;
                  rsp_resp     <= M_AXI_BRESP;
                  rsp_timeout  <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state_q      <= StRsp;
               end
            end
            StRdAddr: begin
               if (ar_hs) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state_q       <= StRdData;
               end
            end
            StRdData: begin
               if (r_hs) begin
                  M_AXI_RREADY <= 1'b0;
                  rsp_rdata    <= M_AXI_RDATA;
                  rsp_resp     <= M_AXI_RRESP;
                  rsp_timeout  <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state_q      <= StRsp;
               end
            end
            StRsp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase

         if (tmo_fire) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b10;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state_q       <= StRsp;
         end
      end
   end

endmodule

// File: tb/tb_axil_reg_master.sv
// Bench for axil_reg_master: a delay-configurable AXI4-Lite slave with a small register map,
// directed vectors, corner-case sequences and randomized traffic against a reference model.
module tb_axil_reg_master;

   localparam int unsigned Tmo = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  WSTRB;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [1:0]  BRESP, RRESP;

   always #5 clk = ~clk;

   axil_reg_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(Tmo)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
      .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
      .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
      .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
      .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   // ---------------- slave model: regs 0x00/0x04 writable, 0x08/0x0C constant ----------------
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   bit          ar_never;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic        aw_got, w_got, ar_got, aw_hs_q, w_hs_q, ar_hs_q;
   logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
   logic [3:0]  w_strb_l;
   logic [31:0] mem [2];
   int          aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, viol_n, split_n;

   logic        aw_hs, w_hs, ar_hs, aw_done, w_done, ar_done;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic [3:0]  wr_strb;

   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign ar_hs   = ARVALID & ARREADY;
   assign aw_done = aw_got | aw_hs;
   assign w_done  = w_got | w_hs;
   assign ar_done = ar_got | ar_hs;
   assign wr_addr = aw_got ? aw_addr_l : AWADDR;
   assign wr_data = w_got ? w_data_l : WDATA;
   assign wr_strb = w_got ? w_strb_l : WSTRB;
   assign rd_addr = ar_got ? ar_addr_l : ARADDR;

   function automatic logic [31:0] slave_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] slave_read(input logic [31:0] a);
      case (a)
         32'h0:   return mem[0];
         32'h4:   return mem[1];
         32'h8:   return 32'h0000_0039;
         32'hC:   return 32'h0000_0098;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         AWREADY <= 0; WREADY <= 0; BVALID <= 0; ARREADY <= 0; RVALID <= 0;
         BRESP <= 0; RRESP <= 0; RDATA <= 0;
         aw_got <= 0; w_got <= 0; ar_got <= 0; aw_hs_q <= 0; w_hs_q <= 0; ar_hs_q <= 0;
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         mem[0] <= 0; mem[1] <= 0;
      end else begin
         aw_hs_q <= aw_hs; w_hs_q <= w_hs; ar_hs_q <= ar_hs;
         viol_n  <= viol_n + int'(aw_hs_q & AWVALID) + int'(w_hs_q & WVALID)
                           + int'(ar_hs_q & ARVALID);
         split_n <= split_n + int'(!AWVALID & WVALID);
         if (aw_hs) begin
            AWREADY <= 0; aw_got <= 1; aw_addr_l <= AWADDR; aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1;
         end else if (AWVALID && !aw_got && !AWREADY) begin
            if (aw_cnt >= aw_dly) AWREADY <= 1; else aw_cnt <= aw_cnt + 1;
         end
         if (w_hs) begin
            WREADY <= 0; w_got <= 1; w_data_l <= WDATA; w_strb_l <= WSTRB; w_cnt <= 0;
            w_hs_n <= w_hs_n + 1;
         end else if (WVALID && !w_got && !WREADY) begin
            if (w_cnt >= w_dly) WREADY <= 1; else w_cnt <= w_cnt + 1;
         end
         if (BVALID && BREADY) begin
            BVALID <= 0; aw_got <= 0; w_got <= 0; b_cnt <= 0; b_hs_n <= b_hs_n + 1;
         end else if (aw_done && w_done && !BVALID) begin
            if (b_cnt >= b_dly) begin
               BVALID <= 1; BRESP <= 2'b00;
               if (wr_addr == 32'h0) mem[0] <= slave_merge(mem[0], wr_data, wr_strb);
               if (wr_addr == 32'h4) mem[1] <= slave_merge(mem[1], wr_data, wr_strb);
            end else b_cnt <= b_cnt + 1;
         end
         if (ar_hs) begin
            ARREADY <= 0; ar_got <= 1; ar_addr_l <= ARADDR; ar_cnt <= 0; ar_hs_n <= ar_hs_n + 1;
         end else if (ARVALID && !ar_got && !ARREADY && !ar_never) begin
            if (ar_cnt >= ar_dly) ARREADY <= 1; else ar_cnt <= ar_cnt + 1;
         end
         if (RVALID && RREADY) begin
            RVALID <= 0; ar_got <= 0; r_cnt <= 0; r_hs_n <= r_hs_n + 1;
         end else if (ar_done && !RVALID) begin
            if (r_cnt >= r_dly) begin
               RVALID <= 1; RDATA <= slave_read(rd_addr); RRESP <= 2'b00;
            end else r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- reference model: register contents as plain words ----------------
   logic [31:0] ref_regs [2];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (a == 32'h0) return ref_regs[0];
      if (a == 32'h4) return ref_regs[1];
      if (a == 32'h8) return 32'd57;
      if (a == 32'hC) return 32'd152;
      return 32'd0;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      if (a == 32'h0) ref_regs[0] = (ref_regs[0] & ~mask) | (d & mask);
      if (a == 32'h4) ref_regs[1] = (ref_regs[1] & ~mask) | (d & mask);
   endtask

   // ---------------- checking helpers ----------------
   int checks = 0, errors = 0;
   int exp_aw = 0, exp_w = 0, exp_b = 0, exp_ar = 0, exp_r = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_rsp"}, 64'({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
      check({tag, "_axi_ctl"}, 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);
      check({tag, "_axi_addr"}, {AWADDR, ARADDR}, 64'd0);
      check({tag, "_axi_data"}, 64'({WDATA, WSTRB, AWPROT, ARPROT}), 64'd0);
   endtask

   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int hold, output logic [31:0] rdata,
                         output logic [1:0] resp, output logic tmo, output int lat);
      int k;
      cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
      k = 0;
      while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
      check("cmd_accept_wait", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      check("rsp_wait", 64'(rsp_valid), 64'd1);
      rdata = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout;
      check("rsp_axi_idle", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready}), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("rsp_hold", 64'({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout}),
               64'({1'b1, 1'b0, rdata, resp, tmo}));
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      check("rsp_release", 64'({rsp_valid, cmd_ready}), 64'd1);
   endtask

   task automatic run_check(input string name, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                            input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                            input bit exp_tmo, input int exp_lat);
      logic [31:0] rd;
      logic [1:0]  rs;
      logic        tm;
      int          lat;
      do_txn(wr, addr, wdata, strb, hold, rd, rs, tm, lat);
      check({name, "_rdata"}, 64'(rd), 64'(exp_rdata));
      check({name, "_resp"}, 64'(rs), 64'(exp_resp));
      check({name, "_timeout"}, 64'(tm), 64'(exp_tmo));
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      if (!exp_tmo) begin
         if (wr) begin exp_aw++; exp_w++; exp_b++; end
         else begin exp_ar++; exp_r++; end
      end
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          hold;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] alist [6];
   logic [31:0] a, d, e;
   logic [3:0]  s;
   bit          wr;
   int          sp0, lat_e;
   bit          seen;

   initial begin
      vecs[0] = '{1'b1, 32'h00, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
      vecs[1] = '{1'b0, 32'h00, 32'h0,         4'h0, 3, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 32'h00, 32'h1122_3344, 4'h5, 0, 32'h0};
      vecs[3] = '{1'b0, 32'h00, 32'h0,         4'h0, 2, 32'hDE22_BE44};
      vecs[4] = '{1'b0, 32'h08, 32'h0,         4'h0, 0, 32'h0000_0039};
      vecs[5] = '{1'b0, 32'h0C, 32'h0,         4'h0, 0, 32'h0000_0098};
      vecs[6] = '{1'b0, 32'h40, 32'h0,         4'h0, 0, 32'h0};
      alist = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h100};

      aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0; viol_n = 0; split_n = 0;
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; ar_never = 0;
      ref_regs[0] = 0; ref_regs[1] = 0;
      cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check_reset_outputs("reset");

      // directed vectors against a zero-delay slave
      for (int i = 0; i < 7; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].strb, vecs[i].hold, vecs[i].exp_rdata, 2'b00, 1'b0, 4);
         if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      end

      // AWREADY three cycles ahead of WREADY, BVALID five cycles late
      aw_dly = 0; w_dly = 3; b_dly = 5;
      sp0 = split_n;
      run_check("split_wr", 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 2'b00, 1'b0, 12);
      ref_write(32'h4, 32'hCAFE_F00D, 4'hF);
      check("split_wr_aw_low_w_high_cycles", 64'(split_n - sp0), 64'd3);
      w_dly = 0; b_dly = 0;
      run_check("split_rd", 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 2'b00, 1'b0, 4);

      // ARREADY never comes: abort after Tmo cycles, then the next command still works
      ar_never = 1;
      run_check("tmo_rd", 1'b0, 32'h8, 32'h0, 4'h0, 2, 32'h0, 2'b10, 1'b1, Tmo + 1);
      ar_never = 0;
      run_check("post_tmo", 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0000_0039, 2'b00, 1'b0, 4);

      // reset while waiting in WR_RESP with the write response still pending
      b_dly = 8;
      cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h4; cmd_wdata = 32'h55AA_55AA; cmd_wstrb = 4'hF;
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 0;
      repeat (3) begin @(posedge clk); #1; end
      check("midrst_in_wrresp", 64'({BREADY, BVALID}), 64'd2);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      exp_aw++; exp_w++;
      check_reset_outputs("midrst");
      seen = 0;
      repeat (20) begin @(posedge clk); #1; seen |= rsp_valid; end
      check("midrst_no_rsp", 64'(seen), 64'd0);
      ref_regs[0] = 0; ref_regs[1] = 0;
      b_dly = 0;
      run_check("midrst_rd", 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h0, 2'b00, 1'b0, 4);

      // randomized traffic with random channel delays
      for (int i = 0; i < 30; i++) begin
         wr = 1'($urandom_range(0, 1));
         a = alist[$urandom_range(0, 5)];
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
         b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
         r_dly = $urandom_range(0, 3);
         if (wr) begin
            lat_e = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 4;
            run_check($sformatf("rnd%0d_wr", i), 1'b1, a, d, s, 0, 32'h0, 2'b00, 1'b0, lat_e);
            ref_write(a, d, s);
         end else begin
            e = ref_read(a);
            lat_e = ar_dly + r_dly + 4;
            run_check($sformatf("rnd%0d_rd", i), 1'b0, a, 32'h0, 4'h0, $urandom_range(0, 2),
                      e, 2'b00, 1'b0, lat_e);
         end
      end

      check("hs_count_aw", 64'(aw_hs_n), 64'(exp_aw));
      check("hs_count_w", 64'(w_hs_n), 64'(exp_w));
      check("hs_count_b", 64'(b_hs_n), 64'(exp_b));
      check("hs_count_ar", 64'(ar_hs_n), 64'(exp_ar));
      check("hs_count_r", 64'(r_hs_n), 64'(exp_r));
      check("valid_after_hs", 64'(viol_n), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
